iref_dispatch_scheduler: RTL and testbench
==========================================

// Module: iref_dispatch_scheduler
// PURPOSE
//  Schedules current-reference updates to the 4 vector-control (VC) channels. The host stages per-channel
//  iref values and commits them as a set; each control tick, the set is dispatched to channels 0..3,
//  one channel per cycle, as 1-cycle valid strobes. Sits between the CPU register slave and the vc_iref*
//  streams. Forces zero current on drive fault or on command-watchdog timeout.
// PARAMETERS
//  NUM_CH         4      channel count (design verified at 4 only)
//  DATA_W         32     signed iref width, two's complement
//  WDT_W          16     watchdog counter width
//  TIMEOUT_TICKS  100    ticks without a commit before timeout fault; 1..2**WDT_W-1
//  SLEW_MAX       1024   max |delta| per dispatch (IREF_SLEW_LIMIT_EN only)
// PORTS
//  clk            in   1               system clock
//  reset          in   1               async active-high reset
//  wr_en          in   1               stage wr_data into staging[wr_chan]
//  wr_chan        in   2               staging channel index
//  wr_data        in   DATA_W          signed iref target
//  commit         in   1               staging -> committed set; kicks watchdog
//  tick           in   1               control-period strobe, 1 cycle
//  fault_in       in   1               OR of driver/hall/encoder faults, level
//  iref_data      out  NUM_CH*DATA_W   ch n at [n*DATA_W +: DATA_W], held between strobes
//  iref_valid     out  NUM_CH          1-cycle strobe per channel
//  fault_out      out  1               registered (fault_in | timeout)
//  timeout        out  1               watchdog expired
//  overrun        out  1               sticky: tick arrived while dispatching; cleared by commit
//  busy           out  1               FSM not IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; staging, committed, and watchdog cleared; FSM=IDLE.
//  - Write and commit in the same cycle: the write lands first and is part of the committed set.
//  - FSM: IDLE -tick-> DISP(0) -> DISP(1) -> DISP(2) -> DISP(3) -> IDLE.
//    On the tick cycle, committed set is copied to shadow. A commit after the tick affects only the next tick.
//  - DISP(n): iref_data[n] is updated and iref_valid[n]=1 for that cycle. Tick at cycle T gives valid[0] at T+1
//    and valid[3] at T+4.
//  - Tick while busy: ignored, overrun=1. Tick in the same cycle as the DISP(3)->IDLE transition is also ignored.
//  - Watchdog: counts ticks since the last commit and saturates. At count==TIMEOUT_TICKS, timeout=1.
//    The next commit clears the count and timeout in the following cycle.
//  - Dispatched value is 0 if fault_in or timeout is set at the DISP(n) cycle; otherwise it is shadow[n].
//    The fault check is per channel, so a mid-sequence fault zeroes the remaining channels.
//  - fault_out = registered (fault_in | timeout), 1 cycle latency.
//  - Reset asserted mid-dispatch: immediate abort, outputs 0, no further strobes.
// CONFIGURATION
//  IREF_SLEW_LIMIT_EN defined:
//   - out_n = last_n + clamp(target - last_n, -SLEW_MAX, +SLEW_MAX).
//   - Difference is computed at DATA_W+1 bits, with no wrap.
//   - Fault/timeout zeroing bypasses the limiter (immediate 0) and sets last_n = 0.
//  Not defined:
//   - out_n = target directly; no limiter logic is instantiated.
// STRUCTURE
//  Package iref_disp_pkg: state enum {IDLE, DISP}, CH_W=$clog2(NUM_CH), IREF_ZERO, channel-slice function.
//  Sub-module iref_slew_limiter: one combinational clamp instance, time-shared across channels by the
//  DISP index, present only under IREF_SLEW_LIMIT_EN.
// TESTING
//  1. Stage ch0..3 = 100, -200, 300, -400, commit, tick at T
//     -> valid[0..3] at T+1..T+4 with exactly those values, busy for 4 cycles.
//  2. Tick at T+2 of a dispatch -> ignored, overrun=1, no extra strobes; next commit clears overrun.
//  3. TIMEOUT_TICKS=3, no commit after ticks 1..3
//     -> timeout=1 after tick 3; tick 4 dispatches all 0; commit clears timeout.
//  4. fault_in rises at the DISP(1) cycle -> ch0 = target, ch1..3 = 0, fault_out=1 one cycle later.
//  5. Write ch2=500 with commit in the same cycle, tick -> ch2 dispatched 500.
//     Commit 700 at T+1 of a dispatch -> 500 still sent; next tick sends 700.
//  6. IREF_SLEW_LIMIT_EN, SLEW_MAX=1024, target 0 -> 3000 -> ticks give 1024, 2048, 3000.
//     Then fault -> 0 immediately.

Source files
------------

// File: rtl/iref_disp_pkg.sv
// Shared types and constants for the iref dispatch scheduler and its optional slew limiter.
package iref_disp_pkg;

  localparam int IREF_NUM_CH = 4;
  localparam int IREF_DATA_W = 32;
  localparam int CH_W        = $clog2(IREF_NUM_CH);

  localparam logic [IREF_DATA_W-1:0] IREF_ZERO = '0;

  typedef enum logic {
    IDLE,
    DISP
  } disp_state_e;

  // Extracts channel ch from a packed NUM_CH*DATA_W iref bus.
  function automatic logic [IREF_DATA_W-1:0] ch_slice(
    input logic [IREF_NUM_CH*IREF_DATA_W-1:0] bus,
    input logic [CH_W-1:0]                    ch
  );
    return bus[ch*IREF_DATA_W +: IREF_DATA_W];
  endfunction

endpackage

// File: rtl/iref_slew_limiter.sv
// Combinational per-dispatch slew clamp; only built when IREF_SLEW_LIMIT_EN is defined.
// out = last + clamp(target - last, -SLEW_MAX, +SLEW_MAX), difference taken one bit wider.
`ifdef IREF_SLEW_LIMIT_EN
module iref_slew_limiter #(
  parameter int DATA_W   = 32,
  parameter int SLEW_MAX = 1024
) (
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] last,
  output logic [DATA_W-1:0] limited
);

  localparam logic signed [DATA_W:0] STEP_POS = (DATA_W+1)'(SLEW_MAX);
  localparam logic signed [DATA_W:0] STEP_NEG = -STEP_POS;

  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] step;

  always_comb begin
    diff = $signed({target[DATA_W-1], target}) - $signed({last[DATA_W-1], last});
    step = diff;
    if (diff > STEP_POS) begin
      step = STEP_POS;
    end else if (diff < STEP_NEG) begin
      step = STEP_NEG;
    end
    // The result lies between last and target, so truncation never wraps.
    limited = DATA_W'($signed({last[DATA_W-1], last}) + step);
  end

endmodule
`endif

// File: rtl/iref_dispatch_scheduler.sv
// Stages/commits per-channel current references and dispatches them one channel per cycle on each tick.
// Define IREF_SLEW_LIMIT_EN to rate-limit each dispatched value against the channel's last output.
module iref_dispatch_scheduler
  import iref_disp_pkg::*;
#(
  parameter int NUM_CH        = IREF_NUM_CH,
  parameter int DATA_W        = IREF_DATA_W,
  parameter int WDT_W         = 16,
  parameter int TIMEOUT_TICKS = 100
`ifdef IREF_SLEW_LIMIT_EN
  , parameter int SLEW_MAX    = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_chan,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     commit,
  input  logic                     tick,
  input  logic                     fault_in,
  output logic [NUM_CH*DATA_W-1:0] iref_data,
  output logic [NUM_CH-1:0]        iref_valid,
  output logic                     fault_out,
  output logic                     timeout,
  output logic                     overrun,
  output logic                     busy
);

  localparam logic [WDT_W-1:0] TIMEOUT_CNT = WDT_W'(TIMEOUT_TICKS);
  localparam logic [CH_W-1:0]  LAST_IDX    = CH_W'(NUM_CH - 1);

  logic [DATA_W-1:0] staging_q   [NUM_CH];
  logic [DATA_W-1:0] staging_d   [NUM_CH];
  logic [DATA_W-1:0] committed_q [NUM_CH];
  logic [DATA_W-1:0] committed_d [NUM_CH];
  logic [DATA_W-1:0] shadow_q    [NUM_CH];
  logic [DATA_W-1:0] shadow_d    [NUM_CH];
  logic [DATA_W-1:0] held_q      [NUM_CH];
  logic [DATA_W-1:0] held_d      [NUM_CH];

  disp_state_e       state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic              overrun_q, overrun_d;
  logic              fault_out_q, fault_out_d;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] disp_val;

  assign target = shadow_q[idx_q];

`ifdef IREF_SLEW_LIMIT_EN
  // held_q doubles as the limiter's "last" value, so fault zeroing resets the ramp origin.
  iref_slew_limiter #(
    .DATA_W   (DATA_W),
    .SLEW_MAX (SLEW_MAX)
  ) u_slew (
    .target  (target),
    .last    (held_q[idx_q]),
    .limited (disp_val)
  );
`else
  assign disp_val = target;
`endif

  always_comb begin
    staging_d = staging_q;
    if (wr_en) begin
      staging_d[wr_chan] = wr_data;
    end
    committed_d = commit ? staging_d : committed_q;

    wdt_d = wdt_q;
    if (commit) begin
      wdt_d = '0;
    end else if (tick && (wdt_q != TIMEOUT_CNT)) begin
      wdt_d = wdt_q + 1'b1;
    end
    timeout = (wdt_q == TIMEOUT_CNT);

    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    if (commit) begin
      overrun_d = 1'b0;
    end

    held_d     = held_q;
    iref_valid = '0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = DISP;
          idx_d    = '0;
          shadow_d = committed_q;
        end
      end
      DISP: begin
        // A tick landing during dispatch (including the final channel) is dropped and flagged.
        if (tick) begin
          overrun_d = 1'b1;
        end
        iref_valid[idx_q] = 1'b1;
        held_d[idx_q]     = (fault_in || timeout) ? IREF_ZERO : disp_val;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fault_out_d = fault_in || timeout;

    for (int n = 0; n < NUM_CH; n++) begin
      iref_data[n*DATA_W +: DATA_W] = held_d[n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        staging_q[n]   <= IREF_ZERO;
        committed_q[n] <= IREF_ZERO;
        shadow_q[n]    <= IREF_ZERO;
        held_q[n]      <= IREF_ZERO;
      end
      state_q     <= IDLE;
      idx_q       <= '0;
      wdt_q       <= '0;
      overrun_q   <= 1'b0;
      fault_out_q <= 1'b0;
    end else begin
      staging_q   <= staging_d;
      committed_q <= committed_d;
      shadow_q    <= shadow_d;
      held_q      <= held_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdt_q       <= wdt_d;
      overrun_q   <= overrun_d;
      fault_out_q <= fault_out_d;
    end
  end

  assign fault_out = fault_out_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == DISP);

endmodule

// File: tb/tb_iref_dispatch_scheduler.sv
// Randomized, model-checked bench for iref_dispatch_scheduler (watchdog shortened to 3 ticks).
// Slew scenario is only exercised when IREF_SLEW_LIMIT_EN is defined.
module tb_iref_dispatch_scheduler;
  import iref_disp_pkg::*;

  localparam int     TO_TICKS = 3;
  localparam longint SLEW     = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en, commit, tick, fault_in;
  logic [1:0]   wr_chan;
  logic [31:0]  wr_data;
  logic [127:0] iref_data;
  logic [3:0]   iref_valid;
  logic         fault_out, timeout, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain arrays, a dispatch position (-1 = not dispatching) and a tick count.
  logic signed [31:0] m_stage [4];
  logic signed [31:0] m_commit[4];
  logic signed [31:0] m_shadow[4];
  logic signed [31:0] m_last  [4];
  logic signed [31:0] m_cur;
  int m_idx;
  int m_ticks;
  bit m_ov;
  bit m_fo;

  always #5 clk = ~clk;

  iref_dispatch_scheduler #(
    .NUM_CH        (4),
    .DATA_W        (32),
    .WDT_W         (16),
    .TIMEOUT_TICKS (TO_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_chan    (wr_chan),
    .wr_data    (wr_data),
    .commit     (commit),
    .tick       (tick),
    .fault_in   (fault_in),
    .iref_data  (iref_data),
    .iref_valid (iref_valid),
    .fault_out  (fault_out),
    .timeout    (timeout),
    .overrun    (overrun),
    .busy       (busy)
  );

  function automatic bit m_timeout();
    return m_ticks >= TO_TICKS;
  endfunction

  function automatic logic signed [31:0] model_out(int n, bit zero);
`ifdef IREF_SLEW_LIMIT_EN
    longint d;
    d = longint'(m_shadow[n]) - longint'(m_last[n]);
    if (d > SLEW) d = SLEW;
    if (d < -SLEW) d = -SLEW;
    return zero ? 32'sd0 : 32'(longint'(m_last[n]) + d);
`else
    return zero ? 32'sd0 : m_shadow[n];
`endif
  endfunction

  function automatic logic [3:0] exp_valid();
    return (m_idx >= 0) ? (4'b0001 << m_idx) : 4'b0000;
  endfunction

  function automatic logic [127:0] exp_bus();
    logic [127:0] b;
    for (int n = 0; n < 4; n++) b[n*32 +: 32] = (n == m_idx) ? m_cur : m_last[n];
    return b;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 4; n++) begin
      m_stage[n] = 0; m_commit[n] = 0; m_shadow[n] = 0; m_last[n] = 0;
    end
    m_cur = 0; m_idx = -1; m_ticks = 0; m_ov = 0; m_fo = 0;
  endfunction

  // Applies the clock edge to the model using the inputs held during the cycle just ending.
  function automatic void model_edge();
    int nxt;
    bit to;
    to  = m_timeout();
    nxt = m_idx;
    if (m_idx >= 0) begin
      m_last[m_idx] = m_cur;
      nxt = (m_idx == 3) ? -1 : m_idx + 1;
    end
    if (commit) m_ov = 0;
    if (tick && m_idx >= 0) m_ov = 1;
    if (tick && m_idx < 0) begin
      m_shadow = m_commit;
      nxt = 0;
    end
    if (wr_en) m_stage[wr_chan] = wr_data;
    if (commit) m_commit = m_stage;
    if (commit) m_ticks = 0;
    else if (tick && m_ticks < TO_TICKS) m_ticks++;
    m_fo  = fault_in || to;
    m_idx = nxt;
  endfunction

  task automatic step(input bit t, input bit c, input bit we, input logic [1:0] ch,
                      input logic [31:0] d, input bit f);
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #2;
    tick = t; commit = c; wr_en = we; wr_chan = ch; wr_data = d; fault_in = f;
    if (m_idx >= 0) m_cur = model_out(m_idx, f || m_timeout());
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick = 0; commit = 0; wr_en = 0; wr_chan = 0; wr_data = 0; fault_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (iref_valid !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid_busy: got valid=%b busy=%b expected 0 0", iref_valid, busy);
    end
    n_checks++;
    if (iref_data !== 128'b0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", iref_data);
    end
    n_checks++;
    if ({fault_out, timeout, overrun} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got fo/to/ov=%b expected 000", {fault_out, timeout, overrun});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_dispatch();
    step(0, 0, 1, 2'd0, 32'sd100, 0);
    step(0, 0, 1, 2'd1, -32'sd200, 0);
    step(0, 0, 1, 2'd2, 32'sd300, 0);
    step(0, 1, 1, 2'd3, -32'sd400, 0);
    step(1, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || iref_valid !== 4'b0) begin
      n_fail++; $display("[TB] FAIL basic_tick_cycle: got busy=%b valid=%b expected 0 0", busy, iref_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2'd0, 0, 0);
      n_checks++;
      if (iref_valid !== exp_valid() || busy !== 1'b1) begin
        n_fail++; $display("[TB] FAIL basic_strobe%0d: got valid=%b busy=%b expected %b 1", k, iref_valid, busy, exp_valid());
      end
      n_checks++;
      if (iref_data !== exp_bus()) begin
        n_fail++; $display("[TB] FAIL basic_data%0d: got %h expected %h", k, iref_data, exp_bus());
      end
    end
    step(0, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || iref_valid !== 4'b0 || iref_data !== exp_bus()) begin
      n_fail++; $display("[TB] FAIL basic_hold: got busy=%b valid=%b data=%h expected 0 0 %h", busy, iref_valid, iref_data, exp_bus());
    end
`ifndef IREF_SLEW_LIMIT_EN
    n_checks++;
    if ($signed(ch_slice(iref_data, 2'd1)) !== -32'sd200 || $signed(ch_slice(iref_data, 2'd3)) !== -32'sd400) begin
      n_fail++; $display("[TB] FAIL basic_literal: got ch1=%0d ch3=%0d expected -200 -400",
                         $signed(ch_slice(iref_data, 2'd1)), $signed(ch_slice(iref_data, 2'd3)));
    end
`endif
  endtask

  task automatic test_overrun();
    step(0, 1, 0, 2'd0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(k == 1, 0, 0, 2'd0, 0, 0);
      n_checks++;
      if (iref_valid !== exp_valid() || iref_data !== exp_bus()) begin
        n_fail++; $display("[TB] FAIL ovr_dispatch%0d: got valid=%b data=%h expected %b %h", k, iref_valid, iref_data, exp_valid(), exp_bus());
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 2'd0, 0, 0);
      n_checks++;
      if (iref_valid !== 4'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
        n_fail++; $display("[TB] FAIL ovr_no_extra%0d: got valid=%b busy=%b ovr=%b expected 0 0 1", k, iref_valid, busy, overrun);
      end
    end
    step(0, 1, 0, 2'd0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (overrun !== m_ov || m_ov !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun);
    end
    // Tick coincident with the last channel's strobe.
    for (int k = 0; k < 4; k++) step(k == 3, 0, 0, 2'd0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (iref_valid !== 4'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovr_last_tick: got valid=%b busy=%b ovr=%b expected 0 0 1", iref_valid, busy, overrun);
    end
    step(0, 1, 0, 2'd0, 0, 0);
  endtask

  task automatic test_timeout();
    for (int n = 0; n < 4; n++) step(0, n == 3, 1, 2'(n), 32'(1000 * (n + 1)), 0);
    for (int t = 1; t <= 4; t++) begin
      step(1, 0, 0, 2'd0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        step(0, 0, 0, 2'd0, 0, 0);
        n_checks++;
        if (timeout !== m_timeout() || iref_valid !== exp_valid() || iref_data !== exp_bus()) begin
          n_fail++; $display("[TB] FAIL wdt_tick%0d_c%0d: got to=%b valid=%b data=%h expected %b %b %h",
                             t, k, timeout, iref_valid, iref_data, m_timeout(), exp_valid(), exp_bus());
        end
      end
      step(0, 0, 0, 2'd0, 0, 0);
    end
    n_checks++;
    if (timeout !== 1'b1 || fault_out !== 1'b1 || iref_data !== 128'b0) begin
      n_fail++; $display("[TB] FAIL wdt_expired: got to=%b fo=%b data=%h expected 1 1 0", timeout, fault_out, iref_data);
    end
    step(0, 1, 0, 2'd0, 0, 0);
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wdt_commit_cycle: got %b expected 1", timeout);
    end
    step(0, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wdt_cleared: got %b expected 0", timeout);
    end
  endtask

  task automatic test_fault();
    for (int n = 0; n < 4; n++) step(0, n == 3, 1, 2'(n), 32'(-77 * (n + 3)), 0);
    step(1, 0, 0, 2'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2'd0, 0, k >= 1);
      n_checks++;
      if (iref_data !== exp_bus() || fault_out !== m_fo) begin
        n_fail++; $display("[TB] FAIL fault_c%0d: got data=%h fo=%b expected %h %b", k, iref_data, fault_out, exp_bus(), m_fo);
      end
    end
    n_checks++;
    if (iref_data[127:32] !== 96'b0 || fault_out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fault_zeroed: got ch1..3=%h fo=%b expected 0 1", iref_data[127:32], fault_out);
    end
    step(0, 0, 0, 2'd0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (fault_out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fault_release: got %b expected 0", fault_out);
    end
  endtask

  task automatic test_same_cycle_commit();
    step(0, 1, 1, 2'd2, 32'sd500, 0);
    step(1, 0, 0, 2'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, k == 0, k == 0, 2'd2, 32'sd700, 0);
      n_checks++;
      if (iref_valid !== exp_valid() || iref_data !== exp_bus()) begin
        n_fail++; $display("[TB] FAIL samecyc_first%0d: got valid=%b data=%h expected %b %h", k, iref_valid, iref_data, exp_valid(), exp_bus());
      end
    end
    step(1, 0, 0, 2'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2'd0, 0, 0);
      n_checks++;
      if (iref_data !== exp_bus()) begin
        n_fail++; $display("[TB] FAIL samecyc_second%0d: got %h expected %h", k, iref_data, exp_bus());
      end
`ifndef IREF_SLEW_LIMIT_EN
      if (k == 2) begin
        n_checks++;
        if ($signed(ch_slice(iref_data, 2'd2)) !== 32'sd700) begin
          n_fail++; $display("[TB] FAIL samecyc_700: got %0d expected 700", $signed(ch_slice(iref_data, 2'd2)));
        end
      end
`endif
    end
    step(0, 0, 0, 2'd0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 4; w++) step(0, w == 3, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, 0);
      step(1, 0, 0, 2'd0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        step(0, 0, 0, 2'd0, 0, $urandom_range(0, 3) == 0);
        n_checks++;
        if (iref_valid !== exp_valid() || iref_data !== exp_bus() || fault_out !== m_fo) begin
          n_fail++; $display("[TB] FAIL rand_it%0d_c%0d: got valid=%b data=%h fo=%b expected %b %h %b",
                             it, k, iref_valid, iref_data, fault_out, exp_valid(), exp_bus(), m_fo);
        end
      end
      step(0, 0, 0, 2'd0, 0, 0);
      n_checks++;
      if (busy !== 1'b0 || iref_data !== exp_bus() || overrun !== m_ov) begin
        n_fail++; $display("[TB] FAIL rand_idle%0d: got busy=%b data=%h ovr=%b expected 0 %h %b", it, busy, iref_data, overrun, exp_bus(), m_ov);
      end
    end
  endtask

  task automatic test_reset_mid_dispatch();
    step(0, 1, 0, 2'd0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (iref_valid !== 4'b0 || busy !== 1'b0 || iref_data !== 128'b0) begin
      n_fail++; $display("[TB] FAIL rst_abort: got valid=%b busy=%b data=%h expected 0 0 0", iref_valid, busy, iref_data);
    end
    step(0, 0, 0, 2'd0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2'd0, 0, 0);
      n_checks++;
      if (iref_valid !== 4'b0 || busy !== 1'b0) begin
        n_fail++; $display("[TB] FAIL rst_no_strobe%0d: got valid=%b busy=%b expected 0 0", k, iref_valid, busy);
      end
    end
  endtask

`ifdef IREF_SLEW_LIMIT_EN
  task automatic test_slew();
    logic signed [31:0] want [5];
    want[0] = 1024; want[1] = 2048; want[2] = 3000; want[3] = 0; want[4] = 1024;
    reset = 1'b1;
    step(0, 0, 0, 2'd0, 0, 0);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) step(0, n == 3, 1, 2'(n), 32'sd3000, 0);
    for (int r = 0; r < 5; r++) begin
      step(1, 0, 0, 2'd0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 2'd0, 0, r == 3);
      step(0, 1, 0, 2'd0, 0, 0);
      n_checks++;
      if ($signed(ch_slice(iref_data, 2'd0)) !== want[r] || iref_data !== exp_bus()) begin
        n_fail++; $display("[TB] FAIL slew_round%0d: got ch0=%0d bus=%h expected %0d %h",
                           r, $signed(ch_slice(iref_data, 2'd0)), iref_data, want[r], exp_bus());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_dispatch();
    test_overrun();
    test_timeout();
    test_fault();
    test_same_cycle_commit();
    test_random();
    test_reset_mid_dispatch();
`ifdef IREF_SLEW_LIMIT_EN
    test_slew();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
